gearbox_rx: RTL and testbench

Receive-side 64b-to-66b gearbox for one PCS lane. It takes raw 64-bit words from the transceiver and repacks them into 66-bit blocks: a 2-bit sync header plus 64 bits of scrambled payload. The blocks feed `pcs_rx` on its `serdes_v_i` / `serdes_head_i` / `serdes_data_i` inputs. `pcs_rx` block lock closes the loop through `gearbox_slip_o`, which drives this block's `slip_i` and shifts block alignment by one bit per slip. The top level instantiates one copy per lane: LANE_N=4 for 40GBASE, 1 for 10GBASE.

---
 rtl/pcs_pkg.sv | 11 +
 rtl/gearbox_rx_if.sv | 22 ++
 rtl/gearbox_rx.sv | 101 ++++++++++
 tb/tb_gearbox_rx.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/pcs_pkg.sv
// Shared PCS constants: block geometry and 64b/66b sync header values.
package pcs_pkg;

  localparam int unsigned HEAD_W  = 2;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned BLOCK_W = HEAD_W + DATA_W;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

endpackage

// File: rtl/gearbox_rx_if.sv
// Transceiver-word in / 66-bit block out bundle for one gearbox_rx lane.
interface gearbox_rx_if #(
  parameter int unsigned HEAD_W = pcs_pkg::HEAD_W,
  parameter int unsigned DATA_W = pcs_pkg::DATA_W
) (
  input logic clk
);

  logic              serdes_v;
  logic [DATA_W-1:0] serdes_data;
  logic              slip;
  logic              valid;
  logic [HEAD_W-1:0] head;
  logic [DATA_W-1:0] data;

  // master drives words and slips, slave returns blocks
  modport master (input clk, output serdes_v, output serdes_data, output slip,
                  input valid, input head, input data);
  modport slave  (input clk, input serdes_v, input serdes_data, input slip,
                  output valid, output head, output data);

endinterface

// File: rtl/gearbox_rx.sv
// Receive 64b-to-66b gearbox: repacks transceiver words into sync-header blocks with bit slip.
// Optional slip lockout counter enabled by defining GEARBOX_RX_SLIP_HOLD_EN.
module gearbox_rx #(
  parameter int unsigned HEAD_W      = pcs_pkg::HEAD_W,
  parameter int unsigned DATA_W      = pcs_pkg::DATA_W,
  parameter int unsigned BLOCK_W     = HEAD_W + DATA_W,
  parameter int unsigned SLIP_HOLD_N = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              serdes_v_i,
  input  logic [DATA_W-1:0] serdes_data_i,
  input  logic              slip_i,
  output logic              valid_o,
  output logic [HEAD_W-1:0] head_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int unsigned BUF_W  = BLOCK_W + DATA_W;
  localparam int unsigned FILL_W = 8;
  localparam logic [BUF_W-1:0] WORD_MASK = {{(BUF_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

  if (BLOCK_W != HEAD_W + DATA_W || SLIP_HOLD_N == 0) begin : g_param_err
    $error("gearbox_rx: inconsistent BLOCK_W or zero SLIP_HOLD_N");
  end

  logic [BUF_W-1:0]  bits_q, bits_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              valid_q, valid_d;
  logic [HEAD_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              slip_ok_c;

`ifdef GEARBOX_RX_SLIP_HOLD_EN
  localparam int unsigned HOLD_W = $clog2(SLIP_HOLD_N + 1);

  logic [HOLD_W-1:0] hold_q, hold_d, hold_dec_c;

  // The counter is decremented before the slip test, so slips land every SLIP_HOLD_N accepting edges
  always_comb begin
    hold_dec_c = (hold_q != '0) ? hold_q - HOLD_W'(1) : '0;
    slip_ok_c  = slip_i && (hold_dec_c == '0);
    hold_d     = hold_q;
    if (serdes_v_i) begin
      hold_d = slip_ok_c ? HOLD_W'(SLIP_HOLD_N) : hold_dec_c;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) hold_q <= '0;
    else         hold_q <= hold_d;
  end
`else
  assign slip_ok_c = slip_i;
`endif

  // Append, then optional one-bit slip, then extract a block once 66 bits are held
  always_comb begin
    bits_d  = bits_q;
    fill_d  = fill_q;
    valid_d = 1'b0;
    head_d  = head_q;
    data_d  = data_q;
    if (serdes_v_i) begin
      bits_d = (bits_q & ~(WORD_MASK << fill_q)) | (BUF_W'(serdes_data_i) << fill_q);
      fill_d = fill_q + FILL_W'(DATA_W);
      if (slip_ok_c) begin
        bits_d = bits_d >> 1;
        fill_d = fill_d - FILL_W'(1);
      end
      if (fill_d >= FILL_W'(BLOCK_W)) begin
        valid_d = 1'b1;
        head_d  = bits_d[HEAD_W-1:0];
        data_d  = bits_d[BLOCK_W-1:HEAD_W];
        bits_d  = bits_d >> BLOCK_W;
        fill_d  = fill_d - FILL_W'(BLOCK_W);
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      bits_q  <= '0;
      fill_q  <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
      data_q  <= '0;
    end else begin
      bits_q  <= bits_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign head_o  = head_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_gearbox_rx.sv
// Self-checking bench for gearbox_rx: bit-queue reference model feeding a block scoreboard.
module tb_gearbox_rx;
  import pcs_pkg::*;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  gearbox_rx_if u_if (.clk(clk));

  gearbox_rx dut (
    .clk           (clk),
    .nreset        (nreset),
    .serdes_v_i    (u_if.serdes_v),
    .serdes_data_i (u_if.serdes_data),
    .slip_i        (u_if.slip),
    .valid_o       (u_if.valid),
    .head_o        (u_if.head),
    .data_o        (u_if.data)
  );

  int checks   = 0;
  int failures = 0;

  logic        src_q[$];
  logic        mdl_q[$];
  logic [65:0] sb_q[$];
  logic [65:0] last_blk;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Serialise pcs_tx-style 66-bit blocks LSB first and chop into 64-bit words
  function automatic logic [63:0] next_word(input bit stuck);
    logic [63:0] w;
    logic [65:0] blk;
    if (stuck) return '1;
    while (src_q.size() < 64) begin
      blk[1:0]  = ($urandom_range(0, 7) == 0) ? SYNC_CTRL : SYNC_DATA;
      blk[65:2] = {$urandom, $urandom};
      for (int i = 0; i < 66; i++) src_q.push_back(blk[i]);
    end
    for (int i = 0; i < 64; i++) w[i] = src_q.pop_front();
    return w;
  endfunction

  task automatic step(input logic v, input logic [63:0] w, input logic s,
                      input logic apply, input string tag);
    logic        exp_v;
    logic [65:0] blk;
    u_if.serdes_v    = v;
    u_if.serdes_data = w;
    u_if.slip        = s;
    exp_v = 1'b0;
    if (v) begin
      for (int i = 0; i < 64; i++) mdl_q.push_back(w[i]);
      if (apply) void'(mdl_q.pop_front());
      if (mdl_q.size() >= 66) begin
        for (int i = 0; i < 66; i++) blk[i] = mdl_q.pop_front();
        sb_q.push_back(blk);
        exp_v = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, " valid"}, 66'(u_if.valid), 66'(exp_v));
    if (exp_v) begin
      last_blk = sb_q.pop_front();
      chk({tag, " block"}, {u_if.data, u_if.head}, last_blk);
    end else begin
      chk({tag, " hold"}, {u_if.data, u_if.head}, last_blk);
    end
  endtask

  task automatic do_reset(input string tag);
    nreset           = 1'b0;
    u_if.serdes_v    = 1'b0;
    u_if.serdes_data = '0;
    u_if.slip        = 1'b0;
    #1;
    chk({tag, " rst valid"}, 66'(u_if.valid), 66'd0);
    chk({tag, " rst block"}, {u_if.data, u_if.head}, 66'd0);
    mdl_q.delete();
    sb_q.delete();
    src_q.delete();
    last_blk = '0;
    @(posedge clk);
    #1;
    nreset = 1'b1;
  endtask

  initial begin
    logic ap;

    // Plain stream: one full 33-word cycle plus the start of the next
    do_reset("init");
    for (int k = 0; k < 35; k++) step(1'b1, next_word(1'b0), 1'b0, 1'b0, "plain");

    // Stuck-at-ones input
    do_reset("stuck");
    for (int k = 0; k < 33; k++) step(1'b1, next_word(1'b1), 1'b0, 1'b0, "stuck");
    chk("stuck last head", 66'(u_if.head), 66'h3);

    // Slip at W5, then 65 more spaced slips (66 total), with an idle gap mid-stream
    do_reset("slip");
    for (int k = 0; k < 5; k++) step(1'b1, next_word(1'b0), 1'b0, 1'b0, "preslip");
    step(1'b1, next_word(1'b0), 1'b1, 1'b1, "slip1");
    for (int n = 1; n < 66; n++) begin
      for (int k = 0; k < 16; k++) step(1'b1, next_word(1'b0), 1'b0, 1'b0, "slipgap");
      if (n == 10) begin
        for (int k = 0; k < 7; k++) step(1'b0, next_word(1'b1), 1'b1, 1'b0, "idle");
      end
      step(1'b1, next_word(1'b0), 1'b1, 1'b1, "slipn");
    end
    for (int k = 0; k < 40; k++) step(1'b1, next_word(1'b0), 1'b0, 1'b0, "realign");

    // Mid-block reset at fill=30 (after 18 words)
    do_reset("mid");
    for (int k = 0; k < 18; k++) step(1'b1, next_word(1'b0), 1'b0, 1'b0, "premid");
    do_reset("midrst");
    step(1'b1, next_word(1'b0), 1'b0, 1'b0, "mid w0");
    step(1'b1, next_word(1'b0), 1'b0, 1'b0, "mid w1");

    // slip_i held high for 40 accepting edges
    do_reset("hold");
    for (int i = 0; i < 40; i++) begin
`ifdef GEARBOX_RX_SLIP_HOLD_EN
      ap = (i % 16 == 0);
`else
      ap = 1'b1;
`endif
      step(1'b1, next_word(1'b0), 1'b1, ap, "holdslip");
    end
    for (int k = 0; k < 10; k++) step(1'b1, next_word(1'b0), 1'b0, 1'b0, "holdtail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
